// File: rtl/aes_pkg.sv
// ============================================================================
//  aes_pkg
//  Shared AES constants, FSM state type and GF(2^8) byte/word helpers.
//  Revision: 1.0
// ============================================================================
`default_nettype none

package aes_pkg;

  localparam int AES_BLOCK = 128;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } fsmState_t;

  function automatic int nr_of(input int nk);
    return nk + 6;
  endfunction

  // MSB index of round key r inside the concatenated expanded key
  function automatic int rkHi(input int nr, input int r);
    return AES_BLOCK * (nr + 1) - 1 - AES_BLOCK * r;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // S-box as multiplicative inverse (b^254) followed by the affine map
  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] r;
    p = b;
    r = 8'h01;
    for (int i = 0; i < 7; i++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] subWord(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [7:0] rcon(input int j);
    logic [7:0] r;
    r = 8'h01;
    for (int i = 1; i < 16; i++) begin
      if (i < j) r = xtime(r);
    end
    return r;
  endfunction

  function automatic logic [31:0] mixCol(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3, t;
    {a0, a1, a2, a3} = c;
    t = a0 ^ a1 ^ a2 ^ a3;
    return {a0 ^ t ^ xtime(a0 ^ a1), a1 ^ t ^ xtime(a1 ^ a2),
            a2 ^ t ^ xtime(a2 ^ a3), a3 ^ t ^ xtime(a3 ^ a0)};
  endfunction

endpackage

`default_nettype wire

// File: rtl/aes_round.sv
// ============================================================================
//  aes_round
//  One combinational AES round; MixColumns bypassed on the final round.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module aes_round
  import aes_pkg::*;
(
  input  logic [AES_BLOCK-1:0] state_in,
  input  logic [AES_BLOCK-1:0] round_key,
  input  logic                 is_final,
  output logic [AES_BLOCK-1:0] state_out
);

  logic [7:0] w_sub   [16];
  logic [7:0] w_shift [16];
  logic [7:0] w_mix   [16];

  // Byte k of the block is row k%4, column k/4
  for (genvar i = 0; i < 16; i++) begin : g_byte
    assign w_sub[i]   = sbox(state_in[AES_BLOCK-1-8*i -: 8]);
    assign w_shift[i] = w_sub[(i % 4) + 4 * (((i / 4) + (i % 4)) % 4)];
    assign state_out[AES_BLOCK-1-8*i -: 8] =
      (is_final ? w_shift[i] : w_mix[i]) ^ round_key[AES_BLOCK-1-8*i -: 8];
  end

  for (genvar c = 0; c < 4; c++) begin : g_col
    assign {w_mix[4*c], w_mix[4*c+1], w_mix[4*c+2], w_mix[4*c+3]} =
      mixCol({w_shift[4*c], w_shift[4*c+1], w_shift[4*c+2], w_shift[4*c+3]});
  end

endmodule

`default_nettype wire

// File: rtl/aes_encrypt_iter.sv
// ============================================================================
//  aes_encrypt_iter
//  Iterative AES-128/192/256 encryptor, one round per clock, valid/ready I/O.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module aes_encrypt_iter
  import aes_pkg::*;
#(
  parameter  int Nk = 4,
  localparam int N  = 32 * Nk,
  localparam int Nr = nr_of(Nk)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [AES_BLOCK-1:0] in,
  input  logic [N-1:0]         key,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [AES_BLOCK-1:0] out,
  output logic                 busy
);

  localparam int NW = 4 * (Nr + 1);

  if (Nk != 4 && Nk != 6 && Nk != 8) begin : g_badNk
    $error("aes_encrypt_iter: Nk must be 4, 6 or 8");
  end

  fsmState_t                  r_fsm, w_fsmNext;
  logic [3:0]                 r_round, w_roundNext;
  logic [N-1:0]               r_key, w_keyNext;
  logic [AES_BLOCK-1:0]       r_state, w_stateNext;
  logic [AES_BLOCK-1:0]       r_out, w_outNext;
  logic                       r_live;
  logic                       w_accept;
  logic                       w_isFinal;
  logic [AES_BLOCK-1:0]       w_roundKey;
  logic [AES_BLOCK-1:0]       w_roundOut;
  logic [31:0]                w_words [NW];
  logic [AES_BLOCK*(Nr+1)-1:0] w_fullKeys;

  // Key schedule runs from the captured key only
  always_comb begin
    logic [31:0] tmp;
    tmp        = '0;
    w_fullKeys = '0;
    for (int i = 0; i < Nk; i++) begin
      w_words[i] = r_key[N-1-32*i -: 32];
    end
    for (int i = Nk; i < NW; i++) begin
      tmp = w_words[i-1];
      if (i % Nk == 0) begin
        tmp = subWord({tmp[23:0], tmp[31:24]}) ^ {rcon(i / Nk), 24'h000000};
      end else if (Nk > 6 && i % Nk == 4) begin
        tmp = subWord(tmp);
      end
      w_words[i] = w_words[i-Nk] ^ tmp;
    end
    for (int i = 0; i < NW; i++) begin
      w_fullKeys[AES_BLOCK*(Nr+1)-1-32*i -: 32] = w_words[i];
    end
  end

  assign w_roundKey = w_fullKeys[rkHi(Nr, int'(r_round)) -: AES_BLOCK];
  assign w_isFinal  = (r_round == 4'(Nr));

  aes_round u_round (
    .state_in  (r_state),
    .round_key (w_roundKey),
    .is_final  (w_isFinal),
    .state_out (w_roundOut)
  );

  assign in_ready  = r_live && ((r_fsm == IDLE) || ((r_fsm == DONE) && out_ready));
  assign w_accept  = in_valid && in_ready;
  assign out_valid = (r_fsm == DONE);
  assign busy      = (r_fsm == ROUND);
  assign out       = r_out;

  always_comb begin
    w_fsmNext   = r_fsm;
    w_roundNext = r_round;
    w_keyNext   = r_key;
    w_stateNext = r_state;
    w_outNext   = r_out;
    case (r_fsm)
      IDLE: begin
        if (w_accept) begin
          w_keyNext   = key;
          w_stateNext = in ^ key[N-1 -: AES_BLOCK];
          w_roundNext = 4'd1;
          w_fsmNext   = ROUND;
        end
      end
      ROUND: begin
        w_stateNext = w_roundOut;
        w_roundNext = r_round + 4'd1;
        if (w_isFinal) begin
          w_outNext   = w_roundOut;
          w_roundNext = 4'd0;
          w_fsmNext   = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          w_fsmNext = IDLE;
          // Same-edge handoff skips the idle bubble
          if (w_accept) begin
            w_keyNext   = key;
            w_stateNext = in ^ key[N-1 -: AES_BLOCK];
            w_roundNext = 4'd1;
            w_fsmNext   = ROUND;
          end
        end
      end
      default: w_fsmNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fsm   <= IDLE;
      r_round <= 4'd0;
      r_key   <= '0;
      r_state <= '0;
      r_out   <= '0;
      r_live  <= 1'b0;
    end else begin
      r_fsm   <= w_fsmNext;
      r_round <= w_roundNext;
      r_key   <= w_keyNext;
      r_state <= w_stateNext;
      r_out   <= w_outNext;
      r_live  <= 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_aes_encrypt_iter.sv
// ============================================================================
//  tb_aes_encrypt_iter
//  Directed + random checks of the AES-128/192/256 iterative encryptors.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_aes_encrypt_iter;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [2:0]       inValid;
  logic [2:0]       outReady;
  logic [2:0][127:0] inB;
  logic [2:0][255:0] keyB;
  wire  [2:0]       inReady;
  wire  [2:0]       outValid;
  wire  [2:0]       busy;
  wire  [2:0][127:0] outB;

  int nChk = 0;
  int nErr = 0;
  logic [7:0] sboxT [256];

  always #5 clk = ~clk;

  aes_encrypt_iter #(.Nk(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(inValid[0]), .in_ready(inReady[0]),
    .in(inB[0]), .key(keyB[0][255 -: 128]), .out_valid(outValid[0]),
    .out_ready(outReady[0]), .out(outB[0]), .busy(busy[0]));
  aes_encrypt_iter #(.Nk(6)) dut6 (
    .clk(clk), .rst_n(rst_n), .in_valid(inValid[1]), .in_ready(inReady[1]),
    .in(inB[1]), .key(keyB[1][255 -: 192]), .out_valid(outValid[1]),
    .out_ready(outReady[1]), .out(outB[1]), .busy(busy[1]));
  aes_encrypt_iter #(.Nk(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(inValid[2]), .in_ready(inReady[2]),
    .in(inB[2]), .key(keyB[2][255 -: 256]), .out_valid(outValid[2]),
    .out_ready(outReady[2]), .out(outB[2]), .busy(busy[2]));

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return 8'((v << n) | (v >> (8 - n)));
  endfunction

  function automatic logic [7:0] m2(input logic [7:0] v);
    return {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] m3(input logic [7:0] v);
    return m2(v) ^ v;
  endfunction

  // Byte-array AES reference following the cipher description directly
  function automatic logic [127:0] refEnc(input int nk, input logic [255:0] k, input logic [127:0] pt);
    logic [7:0] w [240];
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [7:0] tmp [4];
    logic [7:0] a0, a1, a2, a3, f, rc;
    logic [127:0] res;
    int nr;
    nr = nk + 6;
    rc = 8'h01;
    for (int i = 0; i < 4 * nk; i++) w[i] = k[255 - 8 * i -: 8];
    for (int i = nk; i < 4 * (nr + 1); i++) begin
      for (int j = 0; j < 4; j++) tmp[j] = w[4 * (i - 1) + j];
      if (i % nk == 0) begin
        f = tmp[0];
        tmp[0] = sboxT[tmp[1]] ^ rc;
        tmp[1] = sboxT[tmp[2]];
        tmp[2] = sboxT[tmp[3]];
        tmp[3] = sboxT[f];
        rc = m2(rc);
      end else if (nk > 6 && i % nk == 4) begin
        for (int j = 0; j < 4; j++) tmp[j] = sboxT[tmp[j]];
      end
      for (int j = 0; j < 4; j++) w[4 * i + j] = w[4 * (i - nk) + j] ^ tmp[j];
    end
    for (int i = 0; i < 16; i++) s[i] = pt[127 - 8 * i -: 8] ^ w[i];
    for (int r = 1; r <= nr; r++) begin
      for (int i = 0; i < 16; i++) t[i] = sboxT[s[i]];
      for (int c = 0; c < 4; c++)
        for (int rr = 0; rr < 4; rr++) s[rr + 4 * c] = t[rr + 4 * ((c + rr) % 4)];
      if (r != nr) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = m2(a0) ^ m3(a1) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ m2(a1) ^ m3(a2) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ m2(a2) ^ m3(a3);
          s[4*c+3] = m3(a0) ^ a1 ^ a2 ^ m2(a3);
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[16 * r + i];
    end
    for (int i = 0; i < 16; i++) res[127 - 8 * i -: 8] = s[i];
    return res;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    nChk++;
    assert (obs === exp) else begin
      nErr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic scramble(input int d);
    inB[d]  = {$urandom(), $urandom(), $urandom(), $urandom()};
    keyB[d] = {$urandom(), $urandom(), $urandom(), $urandom(),
               $urandom(), $urandom(), $urandom(), $urandom()};
  endtask

  task automatic waitReady(input int d);
    int n;
    n = 0;
    #1;
    while (!inReady[d] && n < 50) begin
      @(negedge clk); #1; n++;
    end
    chk("acceptReady", 128'(inReady[d]), 128'(1));
  endtask

  task automatic runBlock(input int d, input logic [255:0] k, input logic [127:0] pt,
                          input int stall, output logic [127:0] ct);
    int n;
    @(negedge clk);
    inValid[d] = 1'b1; inB[d] = pt; keyB[d] = k; outReady[d] = 1'b0;
    waitReady(d);
    @(posedge clk);
    @(negedge clk);
    inValid[d] = 1'b0;
    scramble(d);
    n = 0;
    while (!outValid[d] && n < 40) begin
      @(negedge clk); scramble(d); n++;
    end
    chk("latency", 128'(n), 128'(10 + 2 * d));
    ct = outB[d];
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      chk("holdValid", 128'(outValid[d]), 128'(1));
      chk("holdOut", outB[d], ct);
    end
    outReady[d] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    outReady[d] = 1'b0;
    chk("dropValid", 128'(outValid[d]), 128'(0));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] keyA, keyBv, rk;
    logic [127:0] ptA, ptB, ct, rp, ctA4, ctB4;
    logic [127:0] fipsExp [3];
    logic [7:0] p, q;
    int n;

    // S-box table from the 3-generator walk of GF(2^8)
    p = 8'h01; q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'h0};
      if (q[7]) q = q ^ 8'h09;
      sboxT[p] = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4) ^ 8'h63;
    end while (p != 8'h01);
    sboxT[0] = 8'h63;

    keyA  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    ptA   = 128'h00112233445566778899aabbccddeeff;
    keyBv = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    ptB   = 128'h3243f6a8885a308d313198a2e0370734;
    fipsExp[0] = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    fipsExp[1] = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    fipsExp[2] = 128'h8ea2b7ca516745bfeafc49904b496089;
    ctA4 = fipsExp[0];
    ctB4 = 128'h3925841d02dc09fbdc118597196a0b32;

    inValid = '0; outReady = '0; inB = '0; keyB = '0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk("rstReady", 128'(inReady[d]), 128'(0));
      chk("rstValid", 128'(outValid[d]), 128'(0));
      chk("rstBusy", 128'(busy[d]), 128'(0));
      chk("rstOut", outB[d], 128'(0));
    end
    rst_n = 1'b1;
    #1 chk("readyBeforeEdge", 128'(inReady[0]), 128'(0));
    @(negedge clk);
    chk("readyAfterEdge", 128'(inReady[0]), 128'(1));

    // Known-answer vectors for all three key sizes
    for (int d = 0; d < 3; d++) begin
      runBlock(d, keyA, ptA, 0, ct);
      chk("fipsVector", ct, fipsExp[d]);
      chk("fipsModel", ct, refEnc(4 + 2 * d, keyA, ptA));
    end

    // Backpressure: output held for 5 stalled cycles
    runBlock(0, keyBv, ptB, 5, ct);
    chk("stallVector", ct, ctB4);

    // Back-to-back with same-edge handoff; second block waits during rounds
    @(negedge clk);
    outReady[0] = 1'b1; inValid[0] = 1'b1; inB[0] = ptB; keyB[0] = keyBv;
    waitReady(0);
    @(posedge clk);
    @(negedge clk);
    inB[0] = ptA; keyB[0] = keyA;
    chk("roundNoReady", 128'(inReady[0]), 128'(0));
    chk("roundBusy", 128'(busy[0]), 128'(1));
    n = 0;
    while (!outValid[0] && n < 40) begin
      @(negedge clk); n++;
      if (!outValid[0]) chk("midRoundNoReady", 128'(inReady[0]), 128'(0));
    end
    chk("b2bLat1", 128'(n), 128'(10));
    chk("b2bOut1", outB[0], ctB4);
    chk("handoffReady", 128'(inReady[0]), 128'(1));
    @(posedge clk);
    @(negedge clk);
    inValid[0] = 1'b0;
    chk("handoffBusy", 128'(busy[0]), 128'(1));
    chk("handoffValid", 128'(outValid[0]), 128'(0));
    n = 0;
    while (!outValid[0] && n < 40) begin
      @(negedge clk); scramble(0); n++;
    end
    chk("b2bLat2", 128'(n), 128'(10));
    chk("b2bOut2", outB[0], ctA4);
    @(posedge clk);
    @(negedge clk);
    outReady[0] = 1'b0;
    chk("b2bDrop", 128'(outValid[0]), 128'(0));

    // Asynchronous reset in the middle of round 5
    inValid[0] = 1'b1; inB[0] = ptB; keyB[0] = keyBv;
    waitReady(0);
    @(posedge clk);
    @(negedge clk);
    inValid[0] = 1'b0;
    repeat (4) @(negedge clk);
    chk("preRstBusy", 128'(busy[0]), 128'(1));
    rst_n = 1'b0;
    #1;
    chk("midRstValid", 128'(outValid[0]), 128'(0));
    chk("midRstOut", outB[0], 128'(0));
    chk("midRstBusy", 128'(busy[0]), 128'(0));
    chk("midRstReady", 128'(inReady[0]), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    runBlock(0, keyBv, ptB, 1, ct);
    chk("postRstVector", ct, ctB4);

    // Random keys/blocks against the reference model
    for (int d = 0; d < 3; d++) begin
      for (int j = 0; j < 4; j++) begin
        rk = {$urandom(), $urandom(), $urandom(), $urandom(),
              $urandom(), $urandom(), $urandom(), $urandom()};
        rp = {$urandom(), $urandom(), $urandom(), $urandom()};
        runBlock(d, rk, rp, int'($urandom_range(0, 3)), ct);
        chk("randomModel", ct, refEnc(4 + 2 * d, rk, rp));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nChk, nErr);
    $finish;
  end

endmodule

`default_nettype wire
